// File: rtl/nrzi_tx_pkg.sv
// Shared NRZI link definitions: FSM state encoding and frame length helper,
// common to the transmitter and the matching receiver.
package nrzi_tx_pkg;

    // Two-bit frame phase encoding used on both ends of the link.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Total clock cycles in one frame: start + DBIT data + stop periods.
    function automatic int unsigned frame_len(input int unsigned dbit,
                                              input int unsigned clks_per_bit);
        return (dbit + 2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/nrzi_tx_bit_timer.sv
// Bit period timer: mod-CLKS_PER_BIT counter with synchronous clear and a
// one-cycle tick while the count sits at its terminal value.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iCLR,
    output logic oMAX_TICK
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (iCLR) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oMAX_TICK = (cnt_q == CNT_MAX);

endmodule

// File: rtl/nrzi_tx.sv
// NRZI line transmitter: start period, DBIT data bits LSB first, stop period.
// A '1' bit toggles the line at the start of its period; a '0' holds it.
// The start period always begins with a toggle so every frame is visible.
module nrzi_tx
    import nrzi_tx_pkg::*;
#(
    parameter int unsigned DBIT         = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic            iCLK,
    input  logic            iRESET,
    input  logic            iSTART,
    input  logic [DBIT-1:0] iDATA,
    output logic            oBUSY,
    output logic            oDONE_TICK,
    output logic            oLEVEL
);

    localparam int unsigned BW = (DBIT > 0) ? $clog2(DBIT + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DBIT - 1);

    tx_state_e       state_q,   state_d;
    logic [DBIT-1:0] shift_q,   shift_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            level_q,   level_d;
    logic            done;
    logic            tick;
    logic            timer_clr;
    logic [DBIT-1:0] shifted;

    // Timer held cleared while idle so each frame starts from count 0.
    assign timer_clr = (state_q == ST_IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iCLR     (timer_clr),
        .oMAX_TICK(tick)
    );

    // Shift-by-one view so the next bit's toggle decision is made on the
    // same edge as the shift, keeping transitions at period starts.
    assign shifted = shift_q >> 1;

    // Frame sequencing, bit shifting and line toggle decisions.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        level_d   = level_q;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    shift_d   = iDATA;
                    bit_cnt_d = '0;
                    level_d   = ~level_q;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    if (shift_q[0]) begin
                        level_d = ~level_q;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (shifted[0]) begin
                            level_d = ~level_q;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, data and line level registers.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            level_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            level_q   <= level_d;
        end
    end

    assign oBUSY      = (state_q != ST_IDLE);
    assign oDONE_TICK = done;
    assign oLEVEL     = level_q;

endmodule

// File: tb/tb_nrzi_tx.sv
// Directed testbench for nrzi_tx with DBIT=8, CLKS_PER_BIT=4.
// Offset k means the clock cycle that follows accept edge T + (k-1).
module tb_nrzi_tx;

    localparam int unsigned DBIT = 8;
    localparam int unsigned CPB  = 4;
    localparam int FRAME = (DBIT + 2) * CPB;

    logic            iCLK;
    logic            iRESET;
    logic            iSTART;
    logic [DBIT-1:0] iDATA;
    logic            oBUSY;
    logic            oDONE_TICK;
    logic            oLEVEL;

    int nchecks = 0;
    int nerrors = 0;
    logic exp_line;

    nrzi_tx #(
        .DBIT        (DBIT),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iSTART    (iSTART),
        .iDATA     (iDATA),
        .oBUSY     (oBUSY),
        .oDONE_TICK(oDONE_TICK),
        .oLEVEL    (oLEVEL)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    typedef struct {
        logic [7:0] data;
        int         trans;
        int         last_off;
        bit         hold;
        bit         pulses;
    } vec_t;

    task automatic chk(input string name, input int act, input int req);
        nchecks++;
        if (act !== req) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected line toggle visible at offset k for a frame carrying d.
    function automatic bit exp_toggle(input logic [7:0] d, input int k);
        int i;
        if (k == 1) return 1'b1;
        if (k >= CPB + 1 && ((k - CPB - 1) % CPB) == 0) begin
            i = (k - CPB - 1) / CPB;
            if (i < DBIT) return d[i];
        end
        return 1'b0;
    endfunction

    // Called at a negedge while idle; sends one frame and checks offsets 1..FRAME.
    task automatic run_frame(input vec_t v);
        int trans = 0, last = 0, busy = 0, done = 0, done_off = 0, lvl_err = 0;
        logic prev;
        prev   = exp_line;
        iDATA  = v.data;
        iSTART = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge iCLK);
            if (exp_toggle(v.data, k)) exp_line = ~exp_line;
            if (oLEVEL !== exp_line) lvl_err++;
            if (oLEVEL !== prev) begin
                trans++;
                last = k;
            end
            prev = oLEVEL;
            if (oBUSY === 1'b1) busy++;
            if (oDONE_TICK === 1'b1) begin
                done++;
                done_off = k;
            end
            if (k == 1) iDATA = ~v.data;
            iSTART = v.hold | (v.pulses & ((k == 10) || (k == FRAME)));
        end
        chk($sformatf("transitions %h", v.data), trans, v.trans);
        chk($sformatf("last_change_offset %h", v.data), last, v.last_off);
        chk($sformatf("level_waveform_errors %h", v.data), lvl_err, 0);
        chk($sformatf("busy_cycles %h", v.data), busy, FRAME);
        chk($sformatf("done_count %h", v.data), done, 1);
        chk($sformatf("done_offset %h", v.data), done_off, FRAME);
    endtask

    // Offset FRAME+1: back in idle, line held, no tick.
    task automatic idle_check(input string name);
        @(negedge iCLK);
        chk({name, " idle_busy"}, int'(oBUSY), 0);
        chk({name, " idle_done"}, int'(oDONE_TICK), 0);
        chk({name, " idle_level"}, int'(oLEVEL), int'(exp_line));
    endtask

    vec_t vecs[6];

    initial begin
        int viol;
        vecs[0] = '{data: 8'hA5, trans: 5, last_off: 33, hold: 1'b0, pulses: 1'b1};
        vecs[1] = '{data: 8'h00, trans: 1, last_off: 1,  hold: 1'b0, pulses: 1'b0};
        vecs[2] = '{data: 8'hFF, trans: 9, last_off: 33, hold: 1'b0, pulses: 1'b0};
        vecs[3] = '{data: 8'h3C, trans: 5, last_off: 25, hold: 1'b1, pulses: 1'b0};
        vecs[4] = '{data: 8'hC3, trans: 5, last_off: 33, hold: 1'b0, pulses: 1'b0};
        vecs[5] = '{data: 8'h01, trans: 2, last_off: 5,  hold: 1'b0, pulses: 1'b0};

        iRESET   = 1'b1;
        iSTART   = 1'b0;
        iDATA    = '0;
        exp_line = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("reset_level", int'(oLEVEL), 0);
        chk("reset_busy", int'(oBUSY), 0);
        chk("reset_done", int'(oDONE_TICK), 0);
        iRESET = 1'b0;

        // Quiet line after reset release.
        viol = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge iCLK);
            if (oLEVEL !== 1'b0 || oBUSY !== 1'b0 || oDONE_TICK !== 1'b0) viol++;
        end
        chk("quiet_after_reset_violations", viol, 0);

        // Frame table: A5 with ignored pulses at offsets 10/40 and accept at 41;
        // 3C then C3 with iSTART held high across the boundary.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
            idle_check($sformatf("frame%0d", i));
        end

        // Reset mid-frame at offset 17 of an FF frame.
        iDATA  = 8'hFF;
        iSTART = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge iCLK);
            if (exp_toggle(8'hFF, k)) exp_line = ~exp_line;
            iSTART = 1'b0;
        end
        chk("abort_pre_busy", int'(oBUSY), 1);
        chk("abort_pre_level", int'(oLEVEL), int'(exp_line));
        iRESET = 1'b1;
        #1;
        chk("abort_level", int'(oLEVEL), 0);
        chk("abort_busy", int'(oBUSY), 0);
        chk("abort_done", int'(oDONE_TICK), 0);
        exp_line = 1'b0;
        @(negedge iCLK);
        iRESET = 1'b0;
        viol = 0;
        for (int c = 0; c < FRAME + 5; c++) begin
            @(negedge iCLK);
            if (oLEVEL !== 1'b0 || oBUSY !== 1'b0 || oDONE_TICK !== 1'b0) viol++;
        end
        chk("abort_quiet_violations", viol, 0);
        run_frame(vecs[5]);
        idle_check("post_abort");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
